// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched shared definitions.
// FSM state encodings and the UART data address decode.
package uart_tx_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } tx_state_t;

    localparam logic [31:0] UART_DATA_ADDR = 32'h1000_0000;

    // cpu_top forms wr_en from the ex-stage store decode with this.
    function automatic logic is_uart_store(
        input logic [31:0] addr,
        input logic        is_store
    );
        return is_store && (addr == UART_DATA_ADDR);
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched bus: CPU store side, transmitter side, status.
// master = CPU/transmitter environment, slave = scheduler.
interface uart_tx_sched_if #(
    parameter int PTR_W = 4,
    parameter int OVF_W = 16
);
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             flush;
    logic             clr_ovf;
    logic             tx_busy;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic [PTR_W:0]   level;
    logic             full;
    logic             empty;
    logic [OVF_W-1:0] ovf_cnt;

    modport master (
        output wr_en, wr_data, flush, clr_ovf, tx_busy,
        input  tx_start, tx_data, level, full, empty, ovf_cnt
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_ovf, tx_busy,
        output tx_start, tx_data, level, full, empty, ovf_cnt
    );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with level counter and flush.
// Full/empty come from the registered level, not pointer compare.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   level,
    output logic             full,
    output logic             empty
);
    localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   level_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_q == FULL_LVL);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage write at the tail.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; level tracks push/pop balance.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// UART transmit scheduler: buffers CPU stores, issues
// one byte per frame to the transmitter, counts drops.
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int PTR_W      = 4,
    parameter int GAP_CYCLES = 0,
    parameter int OVF_W      = 16
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_sched_if.slave bus
);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    tx_state_t        state_q;
    tx_state_t        state_d;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic             ack_q;
    logic             ack_d;
    logic [7:0]       tx_data_q;
    logic [OVF_W-1:0] ovf_q;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    assign pop  = (state_q == IDLE) && !fifo_empty
                  && !bus.tx_busy && !bus.flush;
    assign drop = bus.wr_en && fifo_full && !bus.flush;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .pop   (pop),
        .flush (bus.flush),
        .din   (bus.wr_data),
        .dout  (fifo_dout),
        .level (bus.level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.tx_start = (state_q == ISSUE);
    assign bus.tx_data  = tx_data_q;
    assign bus.ovf_cnt  = ovf_q;

    // State, gap counter and ack timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gap_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state: issue, wait for busy ack, wait frame end, gap.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        ack_d   = ack_q;
        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                ack_d   = 1'b0;
            end
            WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_q) begin
                    state_d = IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_W'(GAP_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Head byte captured on pop, held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_q <= '0;
        end else if (pop) begin
            tx_data_q <= fifo_dout;
        end
    end

    // Saturating drop counter; a clear still counts a same-cycle drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (bus.clr_ovf) begin
            ovf_q <= drop ? OVF_W'(1) : '0;
        end else if (drop && (ovf_q != '1)) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// uart_tx_sched bench: scoreboarded byte order,
// frame spacing, overflow, flush, ack timeout, reset.
module tb_uart_tx_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       flush = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       force_busy = 1'b0;
    logic       ack_en = 1'b1;
    logic [4:0] cnt0;
    logic [4:0] cnt1;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_start0 = 0;
    logic [7:0] q0 [$];
    int         st0 [$];
    int         st1 [$];
    int         fl0 [$];
    int         fl1 [$];

    uart_tx_sched_if #(.PTR_W(4), .OVF_W(16)) b0 ();
    uart_tx_sched_if #(.PTR_W(4), .OVF_W(16)) b1 ();

    uart_tx_sched #(
        .DEPTH(16), .PTR_W(4), .GAP_CYCLES(0), .OVF_W(16)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    uart_tx_sched #(
        .DEPTH(16), .PTR_W(4), .GAP_CYCLES(3), .OVF_W(16)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    always #5 clk = ~clk;

    assign b0.wr_en   = wr_en;
    assign b0.wr_data = wr_data;
    assign b0.flush   = flush;
    assign b0.clr_ovf = clr_ovf;
    assign b0.tx_busy = force_busy | (cnt0 != 5'd0);
    assign b1.wr_en   = wr_en;
    assign b1.wr_data = wr_data;
    assign b1.flush   = flush;
    assign b1.clr_ovf = clr_ovf;
    assign b1.tx_busy = force_busy | (cnt1 != 5'd0);

    // Transmitter models: busy from the cycle after start, 20 cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (b0.tx_start && ack_en && cnt0 == 0) cnt0 <= 5'd20;
            else if (cnt0 != 0) cnt0 <= cnt0 - 1'b1;
            if (b1.tx_start && ack_en && cnt1 == 0) cnt1 <= 5'd20;
            else if (cnt1 != 0) cnt1 <= cnt1 - 1'b1;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h",
                   tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each tx_start, logs timing.
    initial begin
        logic       pb0;
        logic       pb1;
        logic [7:0] exp_b;
        pb0 = 1'b0;
        pb1 = 1'b0;
        forever begin
            @(negedge clk);
            if (b0.tx_start) begin
                n_start0++;
                st0.push_back(cyc);
                check("start_expected", 32'(q0.size() != 0), 1);
                if (q0.size() != 0) begin
                    exp_b = q0.pop_front();
                    check("tx_data", b0.tx_data, exp_b);
                end
            end
            if (b1.tx_start) st1.push_back(cyc);
            if (pb0 && !b0.tx_busy) fl0.push_back(cyc);
            if (pb1 && !b1.tx_busy) fl1.push_back(cyc);
            pb0 = b0.tx_busy;
            pb1 = b1.tx_busy;
        end
    end

    task automatic wr(input logic [7:0] d, input bit sb);
        wr_en   = 1'b1;
        wr_data = d;
        if (sb) q0.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_tx_start"}, b0.tx_start, 0);
        check({pfx, "_tx_data"}, b0.tx_data, 0);
        check({pfx, "_level"}, b0.level, 0);
        check({pfx, "_full"}, b0.full, 0);
        check({pfx, "_empty"}, b0.empty, 1);
        check({pfx, "_ovf"}, b0.ovf_cnt, 0);
    endtask

    initial begin
        int s;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);

        // Single byte latency: start two cycles after the write.
        wr(8'h41, 1);
        check("lat_level_n1", b0.level, 1);
        check("lat_start_n1", b0.tx_start, 0);
        @(negedge clk);
        check("lat_start_n2", b0.tx_start, 1);
        check("lat_data_n2", b0.tx_data, 8'h41);
        check("lat_level_n2", b0.level, 0);
        repeat (25) @(negedge clk);

        // Back-to-back frames, GAP 0 on dut0 and GAP 3 on dut1.
        st0.delete(); st1.delete(); fl0.delete(); fl1.delete();
        wr(8'h48, 1);
        wr(8'h69, 1);
        wr(8'h0A, 1);
        for (int i = 0; i < 200 && q0.size() != 0; i++)
            @(negedge clk);
        repeat (40) @(negedge clk);
        check("b2b_starts0", st0.size(), 3);
        check("b2b_starts1", st1.size(), 3);
        if (st0.size() == 3 && fl0.size() >= 2) begin
            check("gap0_sp1", st0[1] - fl0[0] - 1, 1);
            check("gap0_sp2", st0[2] - fl0[1] - 1, 1);
        end
        if (st1.size() == 3 && fl1.size() >= 2) begin
            check("gap3_sp1", st1[1] - fl1[0] - 1, 4);
            check("gap3_sp2", st1[2] - fl1[1] - 1, 4);
        end

        // Fill while busy: 16 accepted, 2 dropped, then drain in order.
        force_busy = 1'b1;
        for (int i = 0; i < 18; i++)
            wr(8'h80 + 8'(i), i < 16);
        check("ovf_full", b0.full, 1);
        check("ovf_level", b0.level, 16);
        check("ovf_cnt2", b0.ovf_cnt, 2);
        check("ovf_empty", b0.empty, 0);
        force_busy = 1'b0;
        for (int i = 0; i < 1000 && q0.size() != 0; i++)
            @(negedge clk);
        check("drain_done", q0.size(), 0);
        repeat (25) @(negedge clk);

        // Overflow counter: clear with drop, then saturation.
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) wr(8'(i), 0);
        for (int i = 0; i < 3; i++) wr(8'hF0, 0);
        check("ovf_cnt5", b0.ovf_cnt, 5);
        clr_ovf = 1'b1;
        wr(8'hEE, 0);
        clr_ovf = 1'b0;
        check("clr_with_drop", b0.ovf_cnt, 1);
        wr_en = 1'b1;
        repeat (70000) @(negedge clk);
        wr_en = 1'b0;
        check("ovf_sat", b0.ovf_cnt, 16'hFFFF);
        check("sat_level", b0.level, 16);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_only", b0.ovf_cnt, 0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_idle_level", b0.level, 0);
        check("flush_idle_full", b0.full, 0);
        force_busy = 1'b0;
        @(negedge clk);

        // Flush during a frame with a colliding write.
        s = n_start0;
        for (int i = 0; i < 6; i++) wr(8'hC0 + 8'(i), 1);
        for (int i = 0; i < 20 && n_start0 == s; i++)
            @(negedge clk);
        check("fl_first_start", n_start0, s + 1);
        repeat (5) @(negedge clk);
        check("fl_level5", b0.level, 5);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        q0.delete();
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        check("fl_level0", b0.level, 0);
        check("fl_empty", b0.empty, 1);
        check("fl_ovf", b0.ovf_cnt, 0);
        s = n_start0;
        repeat (40) @(negedge clk);
        check("fl_no_start", n_start0, s);

        // No ack from the transmitter: timeout, next byte issues.
        ack_en = 1'b0;
        st0.delete();
        wr(8'hD1, 1);
        wr(8'hD2, 1);
        for (int i = 0; i < 50 && st0.size() < 2; i++)
            @(negedge clk);
        check("noack_starts", st0.size(), 2);
        if (st0.size() == 2)
            check("noack_spacing", st0[1] - st0[0], 4);
        repeat (10) @(negedge clk);
        ack_en = 1'b1;

        // Reset while in WAIT_DONE.
        s = n_start0;
        wr(8'hE1, 1);
        wr(8'hE2, 1);
        wr(8'hE3, 1);
        for (int i = 0; i < 20 && n_start0 == s; i++)
            @(negedge clk);
        check("rst_first_start", n_start0, s + 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        q0.delete();
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        s = n_start0;
        repeat (30) @(negedge clk);
        check("midrst_no_start", n_start0, s);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
